fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 core constants and the fetch-queue entry layout.
package riscv_pkg;

    localparam int              XLEN          = 32;
    localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_BYTES   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; head is read straight from the storage flops.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential imem requests, tracks outstanding
// responses, discards stale ones after a redirect, and queues the rest for decode.
module fetch_unit import riscv_pkg::*; #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = 8;

    // Handshakes: an imem transfer happens on imem_req && imem_gnt, and is answered
    // by exactly one imem_rvalid in order; decode pops on if_valid && if_ready.
    // Neither valid signal ever waits on its own ready.
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] occupancy;
    logic [DW-1:0] drop_cnt;
    logic [CW:0]   outstanding;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic          transfer;
    logic          accept;
    logic          q_push;
    logic          q_pop;

    // inflight counts only live requests; stale ones after a redirect live in drop_cnt.
    assign outstanding = {1'b0, occupancy} + {1'b0, inflight};
    assign imem_req    = !rst && !redirect && (outstanding < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc;
    assign transfer    = imem_req && imem_gnt;
    assign accept      = imem_rvalid && (drop_cnt == '0);
    assign q_push      = accept && !redirect;
    assign q_pop       = if_valid && if_ready && !redirect;
    assign push_entry  = {resp_pc, imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (q_push),
        .wdata (push_entry),
        .pop   (q_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    assign if_valid = !fifo_empty;
    assign if_pc    = if_valid ? head.pc    : resp_pc;
    assign if_instr = if_valid ? head.instr : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect) begin
            fetch_pc <= align_pc(redirect_pc);
            resp_pc  <= align_pc(redirect_pc);
            inflight <= '0;
            drop_cnt <= drop_cnt + DW'(inflight) - DW'(imem_rvalid);
        end else begin
            if (transfer)                fetch_pc <= fetch_pc + INSTR_BYTES;
            if (accept)                  resp_pc  <= resp_pc + INSTR_BYTES;
            if (imem_rvalid && !accept)  drop_cnt <= drop_cnt - 1'b1;
            case ({transfer, accept})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(q_push && fifo_full && !q_pop))
            else $error("fetch queue overflow");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with a reference queue, plus
// directed sequences for stalls, redirects, alignment and address wrap.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_unit #(
        .DEPTH     (DEPTH),
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] a0;
        logic [31:0] a1;
    } redir_vec_t;

    mreq_t       pend[$];
    logic [63:0] exp_q[$];
    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          cyc      = 0;
    int          epoch    = 0;
    int          last_due = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          gnt_pct  = 100;
    logic [31:0] exp_addr = RST_PC;

    logic        smp_req, smp_gnt, smp_valid, smp_ready, smp_rv, smp_rd;
    logic [31:0] smp_addr, smp_pc, smp_instr, smp_rpc;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // ---------------- checkers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_mem();
        imem_gnt = (int'($urandom_range(0, 99)) < gnt_pct);
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        if_ready    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk1 ("rst_req",   imem_req, 1'b0);
        chk1 ("rst_valid", if_valid, 1'b0);
        chk32("rst_instr", if_instr, NOP);
        chk32("rst_pc",    if_pc,    RST_PC);
        pend.delete();
        exp_q.delete();
        epoch++;
        exp_addr = RST_PC;
        last_due = cyc;
        rst = 1'b0;
        drive_mem();
    endtask

    // One clock: sample and check outputs, then update the scoreboard and memory.
    task automatic cycle();
        int    live;
        int    due;
        mreq_t r;
        #1;
        smp_req   = imem_req;   smp_addr  = imem_addr; smp_gnt = imem_gnt;
        smp_rv    = imem_rvalid; smp_rd   = redirect;  smp_rpc = redirect_pc;
        smp_valid = if_valid;   smp_ready = if_ready;
        smp_pc    = if_pc;      smp_instr = if_instr;
        live = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) live++;
        chk1("imem_req", smp_req, ((exp_q.size() + live) < DEPTH) && !smp_rd);
        if (smp_req) chk32("imem_addr", smp_addr, exp_addr);
        chk1("if_valid", smp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk32("if_pc",    smp_pc,    exp_q[0][63:32]);
            chk32("if_instr", smp_instr, exp_q[0][31:0]);
        end else begin
            chk32("if_instr_nop", smp_instr, NOP);
        end

        @(posedge clk);
        @(negedge clk);

        r = '{32'h0, -1, 0};
        if (smp_rv && pend.size() != 0) r = pend.pop_front();
        if (smp_rd) begin
            exp_q.delete();
        end else begin
            if (smp_valid && smp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (smp_rv && r.epoch == epoch) exp_q.push_back({r.addr, mem_word(r.addr)});
        end
        if (smp_req && smp_gnt) begin
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{smp_addr, epoch, due});
            exp_addr = exp_addr + 32'd4;
        end
        if (smp_rd) begin
            epoch++;
            exp_addr = {smp_rpc[31:2], 2'b00};
        end
        cyc++;
        drive_mem();
    endtask

    task automatic wait_first(input string name, input logic [31:0] pc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            cycle();
            if (smp_valid) begin
                found = 1'b1;
                chk32(name, smp_pc, pc);
            end
        end
        chk1({name, "_seen"}, found, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        redir_vec_t tbl[4];
        int         cnt;

        tbl[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
        tbl[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[3] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004};

        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0;

        // Streaming at latency 1: one instruction per cycle from cycle 3.
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        do_reset();
        if_ready = 1'b1;
        cycle();
        chk1 ("first_req",  smp_req,  1'b1);
        chk32("first_addr", smp_addr, RST_PC);
        chk1 ("c1_valid",   smp_valid, 1'b0);
        cycle();
        chk1 ("c2_valid",   smp_valid, 1'b0);
        cycle();
        chk1 ("c3_valid",   smp_valid, 1'b1);
        chk32("c3_pc",      smp_pc,    RST_PC);
        cnt = 0;
        repeat (20) begin
            cycle();
            if (smp_valid && smp_ready) cnt++;
        end
        chk32("throughput", 32'(cnt), 32'd20);

        // Decode stalled at latency 2: queue fills after exactly DEPTH grants.
        lat_min = 2; lat_max = 2;
        do_reset();
        cnt = 0;
        repeat (10) begin
            cycle();
            if (smp_req && smp_gnt) cnt++;
        end
        chk32("stall_grants", 32'(cnt), 32'(DEPTH));
        chk1 ("stall_req",    smp_req,   1'b0);
        chk1 ("stall_valid",  smp_valid, 1'b1);
        if_ready = 1'b1;
        cycle();
        chk32("drain_pc0", smp_pc, RST_PC);
        cnt = 0;
        repeat (4) begin
            cycle();
            if (smp_req) cnt++;
        end
        chk1("resume_req", cnt > 0, 1'b1);

        // Redirect with three requests in flight and no response yet.
        lat_min = 4; lat_max = 4;
        do_reset();
        if_ready = 1'b1;
        repeat (3) cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        cycle();
        chk1 ("r38_valid", smp_valid, 1'b0);
        chk32("r38_instr", smp_instr, NOP);
        chk32("r38_addr",  smp_addr,  32'h0000_0100);
        wait_first("r38_first_pc", 32'h0000_0100);

        // Redirect coinciding with a response and a pop, two in flight.
        lat_min = 2; lat_max = 2;
        do_reset();
        if_ready = 1'b1;
        repeat (3) cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        cycle();
        chk1("r39_pop", smp_valid && smp_ready, 1'b1);
        redirect = 1'b0;
        cycle();
        chk1("r39_valid", smp_valid, 1'b0);
        wait_first("r39_first_pc", 32'h0000_0040);

        // Redirect targets: alignment and address wrap.
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 4; i++) begin
            redirect = 1'b1; redirect_pc = tbl[i].rpc;
            cycle();
            redirect = 1'b0;
            cycle();
            chk1 ("tbl_req0",  smp_req,  1'b1);
            chk32("tbl_addr0", smp_addr, tbl[i].a0);
            cycle();
            chk1 ("tbl_req1",  smp_req,  1'b1);
            chk32("tbl_addr1", smp_addr, tbl[i].a1);
        end
        repeat (6) cycle();

        // Back-to-back redirects: only the last target is delivered.
        lat_min = 3; lat_max = 3;
        repeat (3) cycle();
        for (int i = 5; i < 8; i++) begin
            redirect = 1'b1; redirect_pc = 32'(i) << 8;
            cycle();
        end
        redirect = 1'b0;
        wait_first("b2b_first_pc", 32'h0000_0700);

        // Random traffic with a mid-run reset.
        lat_min = 1; lat_max = 3; gnt_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
            end
            if_ready    = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = $urandom();
            cycle();
        end
        redirect = 1'b0; if_ready = 1'b1; gnt_pct = 100;
        repeat (20) cycle();
        chk1("final_drained", smp_valid, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
